// File: rtl/match_scanner_pkg.sv
// Shared board geometry, cell encoding and scanner state enum.
// Used by the scanner top and its line matcher.
package match_pkg;
  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int CW    = 3;
  localparam int NCELL = ROWS * COLS;
  localparam int BW    = NCELL * CW;
  localparam int IW    = $clog2(COLS);

  localparam logic [CW-1:0] CELL_EMPTY = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN_H = 2'd1,
    SCAN_V = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int cell_off(input int r, input int c);
    return (COLS * r + c) * CW;
  endfunction
endpackage

// File: rtl/match_scanner_line_matcher.sv
// Marks every cell of a line that sits in a run of 3+ equal non-empty cells.
// Purely combinational; no flow control.
module line_matcher
  import match_pkg::*;
(
  input  logic [COLS*CW-1:0] i_cells,
  output logic [COLS-1:0]    o_run
);

  logic [CW-1:0]   w_c [COLS];
  logic [COLS-3:0] w_tri;

  // A maximal run is exactly the union of the triples it contains.
  always_comb begin
    for (int k = 0; k < COLS; k++) begin
      w_c[k] = i_cells[k*CW +: CW];
    end
    for (int k = 0; k < COLS - 2; k++) begin
      w_tri[k] = (w_c[k] != CELL_EMPTY) && (w_c[k] == w_c[k+1]) && (w_c[k+1] == w_c[k+2]);
    end
    o_run = '0;
    for (int i = 0; i < COLS; i++) begin
      for (int k = 0; k < COLS - 2; k++) begin
        if (i >= k && i <= k + 2) begin
          o_run[i] = o_run[i] | w_tri[k];
        end
      end
    end
  end

endmodule

// File: rtl/match_scanner.sv
// Captures a board, scans rows then columns for 3+ runs, reports mask/count.
// Done 16 cycles after capture; board_valid outside IDLE is dropped, not queued.
module match_scanner
  import match_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BW-1:0]     board_in,
  input  logic              board_valid,
  output logic              busy,
  output logic              done,
  output logic [NCELL-1:0]  match_mask,
  output logic              match_found,
  output logic [6:0]        match_count
);

  localparam logic [IW-1:0] LAST_IDX = IW'(COLS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BW-1:0]        r_board;
  logic [NCELL-1:0]     r_acc;
  logic [IW-1:0]        r_idx;
  logic [COLS*CW-1:0]   w_line;
  logic [COLS-1:0]      w_run;
  logic [NCELL-1:0]     w_scatter;
  logic [NCELL-1:0]     w_final;

  function automatic logic [6:0] popcount(input logic [NCELL-1:0] m);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < NCELL; i++) begin
      n = n + 7'(m[i]);
    end
    return n;
  endfunction

  // One matcher serves both passes: pick row idx or column idx.
  always_comb begin
    w_line = '0;
    for (int k = 0; k < COLS; k++) begin
      if (r_state == SCAN_V) begin
        w_line[k*CW +: CW] = r_board[cell_off(k, int'(r_idx)) +: CW];
      end else begin
        w_line[k*CW +: CW] = r_board[cell_off(int'(r_idx), k) +: CW];
      end
    end
  end

  line_matcher u_line (
    .i_cells (w_line),
    .o_run   (w_run)
  );

  always_comb begin
    w_scatter = '0;
    for (int k = 0; k < COLS; k++) begin
      if (r_state == SCAN_V) begin
        w_scatter[COLS*k + int'(r_idx)] = w_run[k];
      end else if (r_state == SCAN_H) begin
        w_scatter[COLS*int'(r_idx) + k] = w_run[k];
      end
    end
  end

  assign w_final = r_acc | w_scatter;

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != IDLE);
    done        = (r_state == DONE);
    case (r_state)
      IDLE:    if (board_valid) w_state_nxt = SCAN_H;
      SCAN_H:  if (r_idx == LAST_IDX) w_state_nxt = SCAN_V;
      SCAN_V:  if (r_idx == LAST_IDX) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_board     <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      match_mask  <= '0;
      match_found <= 1'b0;
      match_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (board_valid) begin
            r_board <= board_in;
            r_acc   <= '0;
            r_idx   <= '0;
          end
        end
        SCAN_H: begin
          r_acc <= w_final;
          r_idx <= r_idx + IW'(1);
        end
        SCAN_V: begin
          r_acc <= w_final;
          r_idx <= r_idx + IW'(1);
          if (r_idx == LAST_IDX) begin
            match_mask  <= w_final;
            match_found <= |w_final;
            match_count <= popcount(w_final);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_match_scanner.sv
// Directed boards with hand-computed masks; a monitor scores each done pulse
// against a queue of expected results, including capture-to-done latency.
module tb_match_scanner;
  import match_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [BW-1:0]     board_in = '0;
  logic              board_valid = 1'b0;
  logic              busy;
  logic              done;
  logic [NCELL-1:0]  match_mask;
  logic              match_found;
  logic [6:0]        match_count;

  match_scanner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .board_in    (board_in),
    .board_valid (board_valid),
    .busy        (busy),
    .done        (done),
    .match_mask  (match_mask),
    .match_found (match_found),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] mask;
    logic [6:0]  cnt;
    logic        found;
    int          due;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int exp_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      done_seen++;
      if (prev_done) check("done_one_cycle", 64'(prev_done), 64'(0));
      if (q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = q.pop_front();
        check("mask", match_mask, e.mask);
        check("count", 64'(match_count), 64'(e.cnt));
        check("found", 64'(match_found), 64'(e.found));
        check("latency", 64'(cyc), 64'(e.due));
        check("busy_at_done", 64'(busy), 64'(1));
      end
    end
    prev_done = rst_n && done;
  end

  function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int r, input int c,
                                        input logic [2:0] v);
    b[(COLS*r + c)*CW +: CW] = v;
    return b;
  endfunction

  function automatic logic [BW-1:0] checker_board();
    logic [BW-1:0] b;
    b = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        b = put(b, r, c, ((r + c) % 2 != 0) ? 3'd2 : 3'd1);
    return b;
  endfunction

  function automatic logic [BW-1:0] gen_board();
    logic [BW-1:0] b;
    b = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        b = put(b, r, c, (c == 4) ? 3'd4 : 3'((r % 6) + 1));
    return b;
  endfunction

  task automatic send(input logic [BW-1:0] b, input bit push, input logic [63:0] emask,
                      input logic [6:0] ecnt);
    exp_t e;
    @(negedge clk);
    board_in    = b;
    board_valid = 1'b1;
    @(posedge clk);
    #1;
    board_valid = 1'b0;
    board_in    = ~b;
    if (push) begin
      e.mask  = emask;
      e.cnt   = ecnt;
      e.found = (emask != 64'd0);
      e.due   = cyc + 16;
      q.push_back(e);
      exp_done++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || q.size() != 0) && n < 60);
    check("idle_reached", 64'(busy), 64'(0));
    check("queue_drained", 64'(q.size()), 64'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_mask"}, match_mask, 64'(0));
    check({tag, "_found"}, 64'(match_found), 64'(0));
    check({tag, "_count"}, 64'(match_count), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] b;
    logic [BW-1:0] cross_b;
    logic [BW-1:0] row_b;

    // Reset behaviour while idle
    repeat (2) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_zero("idle");
    rst_n = 1'b0;
    #1;
    check_zero("rst_idle");
    @(negedge clk);
    rst_n = 1'b1;

    // Generator pattern: every cell in some run
    send(gen_board(), 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64);
    wait_idle();
    repeat (3) @(negedge clk);
    check("hold_mask", match_mask, 64'hFFFF_FFFF_FFFF_FFFF);
    check("hold_count", 64'(match_count), 64'd64);

    // Checkerboard: no runs
    send(checker_board(), 1'b1, 64'd0, 7'd0);
    wait_idle();

    // Empty row ignored, short run in row 2
    row_b = checker_board();
    for (int c = 0; c < COLS; c++) row_b = put(row_b, 0, c, 3'd0);
    for (int c = 5; c < 8; c++) row_b = put(row_b, 2, c, 3'd5);
    send(row_b, 1'b1, 64'h0000_0000_00E0_0000, 7'd3);
    wait_idle();

    // Cross shared cell counted once; a vertical pair stays unmarked
    cross_b = checker_board();
    cross_b = put(cross_b, 4, 2, 3'd3);
    cross_b = put(cross_b, 4, 3, 3'd3);
    cross_b = put(cross_b, 4, 4, 3'd3);
    cross_b = put(cross_b, 5, 4, 3'd3);
    cross_b = put(cross_b, 6, 4, 3'd3);
    cross_b = put(cross_b, 0, 0, 3'd6);
    cross_b = put(cross_b, 1, 0, 3'd6);
    send(cross_b, 1'b1, 64'h0010_101C_0000_0000, 7'd5);
    wait_idle();

    // board_valid during scan is dropped
    send(cross_b, 1'b1, 64'h0010_101C_0000_0000, 7'd5);
    repeat (5) @(posedge clk);
    send(gen_board(), 1'b0, 64'd0, 7'd0);
    wait_idle();
    repeat (20) @(negedge clk);
    check("done_pulses_after_ignore", 64'(done_seen), 64'(exp_done));

    // Reset mid-scan aborts, then next board runs normally
    b = gen_board();
    send(b, 1'b0, 64'd0, 7'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("no_done_after_abort", 64'(done_seen), 64'(exp_done));
    check("mask_after_abort", match_mask, 64'd0);
    send(row_b, 1'b1, 64'h0000_0000_00E0_0000, 7'd3);
    wait_idle();

    check("done_pulses_total", 64'(done_seen), 64'(exp_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
